// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - producer/consumer bundle for sync_fifo
interface sync_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
);
   logic                  clr;
   logic                  w_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  r_en;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output clr, w_en, data_in, r_en,
      input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  clr, w_en, data_in, r_en,
      output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with thresholds, sticky errors and flush
// Optional first-word fall-through read port: SYNC_FIFO_FWFT_EN
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 2
) (
   input  logic       clk,
   input  logic       rst,
   sync_fifo_if.slave fifo
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] AF_W = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0] AE_W = (ADDR_WIDTH+1)'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH:0]   w_ptr_q, w_ptr_d;
   logic [ADDR_WIDTH:0]   r_ptr_q, r_ptr_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic [ADDR_WIDTH:0]   count_w;
   logic                  full_w, empty_w;
   logic                  we, re;
   logic [ADDR_WIDTH-1:0] w_addr, r_addr;

   // Status comes only from registered pointers, never from the request inputs.
   assign count_w = w_ptr_q - r_ptr_q;
   assign empty_w = (w_ptr_q == r_ptr_q);
   assign full_w  = (w_ptr_q[ADDR_WIDTH] != r_ptr_q[ADDR_WIDTH]) &&
                    (w_ptr_q[ADDR_WIDTH-1:0] == r_ptr_q[ADDR_WIDTH-1:0]);
   assign w_addr  = w_ptr_q[ADDR_WIDTH-1:0];
   assign r_addr  = r_ptr_q[ADDR_WIDTH-1:0];

   assign we = fifo.w_en & ~full_w  & ~fifo.clr;
   assign re = fifo.r_en & ~empty_w & ~fifo.clr;

   always_comb begin
      w_ptr_d     = w_ptr_q;
      r_ptr_d     = r_ptr_q;
      overflow_d  = overflow_q  | (fifo.w_en & full_w);
      underflow_d = underflow_q | (fifo.r_en & empty_w);
      if (fifo.clr) begin
         w_ptr_d     = '0;
         r_ptr_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (we) w_ptr_d = w_ptr_q + 1'b1;
         if (re) r_ptr_d = r_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_ptr_q     <= '0;
         r_ptr_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         w_ptr_q     <= w_ptr_d;
         r_ptr_q     <= r_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately unreset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (we) mem_q[w_addr] <= fifo.data_in;
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign fifo.data_out = empty_w ? '0 : mem_q[r_addr];
`else
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

   always_comb begin
      data_out_d = data_out_q;
      if (fifo.clr)  data_out_d = '0;
      else if (re)   data_out_d = mem_q[r_addr];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) data_out_q <= '0;
      else      data_out_q <= data_out_d;
   end

   assign fifo.data_out = data_out_q;
`endif

   assign fifo.count        = count_w;
   assign fifo.empty        = empty_w;
   assign fifo.full         = full_w;
   assign fifo.almost_full  = (count_w >= AF_W);
   assign fifo.almost_empty = (count_w <= AE_W);
   assign fifo.overflow     = overflow_q;
   assign fifo.underflow    = underflow_q;
endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Parametrised single-clock FIFO, the next generation of the team's FIFO buffer. Adds configurable width and depth, programmable almost-full and almost-empty thresholds, an occupancy count, sticky overflow and underflow error flags, and a synchronous flush. It is used wherever producer and consumer share one clock, for example as a buffer in front of the async FIFO or inside a single-domain datapath.

Parameters:
DATA_WIDTH  8  width of each stored word
ADDR_WIDTH  3  log2 of depth; DEPTH = 2**ADDR_WIDTH (default 8 words)
AF_LEVEL  6  almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
AE_LEVEL  2  almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
clr  input  1  synchronous flush
w_en  input  1  write request
data_in  input  DATA_WIDTH  write data
r_en  input  1  read request
data_out  output  DATA_WIDTH  read data
full  output  1  FIFO holds DEPTH words
empty  output  1  FIFO holds 0 words
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Pointers: w_ptr and r_ptr are binary, ADDR_WIDTH+1 bits, and wrap naturally modulo 2*DEPTH. Memory is addressed by the low ADDR_WIDTH bits.
- Status decode: all status is decoded combinationally from registered state only; no input-to-flag paths.
  - count = w_ptr - r_ptr, taken modulo 2**(ADDR_WIDTH+1).
  - empty = (w_ptr == r_ptr).
  - full = MSBs differ and low ADDR_WIDTH bits are equal.
- Write acceptance: we = w_en & ~full & ~clr. An accepted write stores data_in at mem[w_ptr] and increments w_ptr.
- Read acceptance: re = r_en & ~empty & ~clr. An accepted read increments r_ptr.
- Acceptance is judged on pre-edge flags only:
  - Full, with w_en and r_en both high: the read is accepted, the write is rejected, and overflow is set.
  - Empty, with w_en and r_en both high: the write is accepted, the read is rejected, and underflow is set.
  - Neither full nor empty, both requests high: both are accepted and count is unchanged.
- Standard read timing: data_out is registered and loads mem[r_ptr] on the edge that accepts a read, so it is valid the cycle after r_en (latency 1). Otherwise data_out holds its value.
- Error flags: overflow is set on any edge with w_en & full. Underflow is set on any edge with r_en & empty. Once set, each stays high until rst or clr.
- clr (synchronous flush): has priority over w_en and r_en. On the edge it:
  - zeroes w_ptr and r_ptr,
  - clears overflow and underflow,
  - resets data_out to 0.
  Memory contents are not cleared; the next cycle reads as empty.
- Reset values: data_out=0, empty=1, full=0, almost_empty=1, almost_full=0, count=0, overflow=0, underflow=0, both pointers 0.
- Reset mid-operation: asserting rst takes outputs to their reset values immediately, independent of clk. Buffered words are discarded. Release rst only when w_en and r_en are low.
- Memory: DEPTH x DATA_WIDTH register array, no reset. Written only by accepted writes.
- No state machine beyond the pointer counters; the FIFO state is fully encoded in w_ptr, r_ptr and the sticky flags.

Optional Feature:
Macro: SYNC_FIFO_FWFT_EN (first-word fall-through).
- Defined:
  - data_out is driven combinationally as empty ? 0 : mem[r_ptr[ADDR_WIDTH-1:0]].
  - The head word is visible whenever empty=0; r_en acts as an acknowledge that pops it.
  - A word written into an empty FIFO appears on data_out in the cycle after the write edge, the same cycle empty deasserts.
  - data_out has no register of its own, so the clr and reset rules apply through empty.
- Undefined: standard registered read with latency 1, as described above.
- All flags, count and acceptance rules are identical in both modes.

Test Plan:
1. Reset with rst=0, then release; write 8 words 0x11..0x88 on consecutive cycles -> count steps 1..8. almost_empty deasserts at count 3, almost_full asserts at count 6, full=1 after the 8th write, overflow stays 0.
2. Full FIFO, w_en=1 with data_in=0x99 for one cycle -> count stays 8, overflow=1 and stays high. Drain all 8 words -> reads return 0x11..0x88 in order, each one cycle after r_en (FWFT: 0x11 present before the first r_en). Final state empty=1, overflow still 1.
3. Empty FIFO, r_en=1 alone -> underflow=1, data_out unchanged, count 0. Then w_en=r_en=1 with data_in=0xA5 -> write accepted, read rejected, count=1.
4. Wrap-around: 20 cycles of simultaneous write/read at steady occupancy 4, data incrementing from 0x00 -> pointers wrap past 16 with output order preserved, count fixed at 4, full=0, empty=0.
5. Occupancy 5 with overflow=1: assert clr together with w_en and r_en -> next cycle count=0, empty=1, overflow=0, data_out=0. The write is not stored; a following single write/read returns the new data.
6. Mid-burst at count 3: pulse rst low between clock edges -> outputs go to reset values immediately without a clk edge. After release, behaviour matches a fresh reset.
